// File: rtl/mw_pkg.sv
// Shared constants for the M->W load stage: load-op encodings, bubble word, reset PC.
package mw_pkg;

    localparam logic [3:0]  LOADOP_WORD      = 4'b0000;
    localparam logic [3:0]  LOADOP_LB        = 4'b0001;
    localparam logic [3:0]  LOADOP_LH        = 4'b0010;

    localparam logic [31:0] NOP_INSTR        = 32'h0;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

    // Sign-extend a byte or halfword to 32 bits.
    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

endpackage

// File: rtl/load_ext.sv
// Combinational load-data extender: picks the addressed byte/half of the read word
// and sign-extends it; unknown load ops pass the full word.
module load_ext
    import mw_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [3:0]  loadop,
    output logic [31:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (off)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        // Halfword select uses only off[1]; a misaligned off[0] is ignored here.
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        ext = rdata;
        case (loadop)
            LOADOP_LB: ext = sext8(byte_sel);
            LOADOP_LH: ext = sext16(half_sel);
            default:   ext = rdata;
        endcase
    end

endmodule

// File: rtl/mw_load_stage.sv
// M->W pipeline register with flush/squash at capture and load-data extension in W.
// Optional retire counter enabled by defining MW_RETIRE_CNT_EN.
module mw_load_stage
    import mw_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       Instruction_M,
    input  logic [31:0]       PC_M,
    input  logic [31:0]       ALUresult_M,
    input  logic [DATA_W-1:0] Result_M,
    input  logic [DATA_W-1:0] m_data_rdata,
    input  logic [3:0]        Loadop,
    input  logic              MemToReg_M,
    input  logic              RegWrite_M,
    input  logic [4:0]        WriteReg_M,
    input  logic              Error_M,
    input  logic              Req,
    output logic [31:0]       Instruction_W,
    output logic [31:0]       PC_W,
    output logic [4:0]        WriteReg_W,
    output logic [DATA_W-1:0] WriteData_W,
    output logic              RegWrite_W
`ifdef MW_RETIRE_CNT_EN
    ,
    output logic [31:0]       retire_cnt
`endif
);

    logic [1:0]        off_q;
    logic [3:0]        loadop_q;
    logic              mem_to_reg_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] ext_data;
    logic              reg_write_next;

    // Only the byte offset of the address is needed downstream.
    logic unused_addr_bits;
    assign unused_addr_bits = ^ALUresult_M[31:2];

    // Exception squash and writes to $0 both suppress the GPR write.
    assign reg_write_next = RegWrite_M && !Error_M && (WriteReg_M != 5'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Instruction_W <= NOP_INSTR;
            PC_W          <= PC_RESET;
            WriteReg_W    <= 5'd0;
            RegWrite_W    <= 1'b0;
            off_q         <= 2'd0;
            loadop_q      <= LOADOP_WORD;
            mem_to_reg_q  <= 1'b0;
            rdata_q       <= '0;
            result_q      <= '0;
        end else if (Req) begin
            Instruction_W <= NOP_INSTR;
            PC_W          <= PC_RESET;
            WriteReg_W    <= 5'd0;
            RegWrite_W    <= 1'b0;
            off_q         <= 2'd0;
            loadop_q      <= LOADOP_WORD;
            mem_to_reg_q  <= 1'b0;
            rdata_q       <= '0;
            result_q      <= '0;
        end else begin
            Instruction_W <= Instruction_M;
            PC_W          <= PC_M;
            WriteReg_W    <= WriteReg_M;
            RegWrite_W    <= reg_write_next;
            off_q         <= ALUresult_M[1:0];
            loadop_q      <= Loadop;
            mem_to_reg_q  <= MemToReg_M;
            rdata_q       <= m_data_rdata;
            result_q      <= Result_M;
        end
    end

    load_ext u_load_ext (
        .rdata  (rdata_q),
        .off    (off_q),
        .loadop (loadop_q),
        .ext    (ext_data)
    );

    assign WriteData_W = mem_to_reg_q ? ext_data : result_q;

`ifdef MW_RETIRE_CNT_EN
    // Counts every real instruction entering W, including squashed ones; wraps freely.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_cnt <= 32'd0;
        end else if (!Req && (Instruction_M != NOP_INSTR)) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end
`endif

endmodule
